sa_fetch_controller: RTL and testbench
======================================

Name: sa_fetch_controller

Overview:
Sequences operand fetches for the systolic array by generating the address/enable/chip-select stream that feeds the delay_block chain in front of the PE columns. On a start pulse it walks a configurable (rows x cols) tile in row-major order, one address per non-stalled cycle. It then drains long enough for the most-delayed column to receive the final element, and signals completion. It sits between the LSTM top-level control and the per-column delay blocks.

Parameters:
FEATURE_BITS, 4, bits per row/col index; address width is 2*FEATURE_BITS.
NUM_PE, 4, PE columns; the deepest delay is NUM_PE-1, so the drain length is NUM_PE cycles.

Ports:
sys_clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
start  in  1  start request, sampled only in IDLE.
abort  in  1  synchronous abort, any state.
stall  in  1  hold issue for this cycle (RUN only).
rows_cfg  in  FEATURE_BITS  number of rows minus 1, latched at start.
cols_cfg  in  FEATURE_BITS  number of cols minus 1, latched at start.
address_out  out  2*FEATURE_BITS  {row,col}; row in upper FEATURE_BITS, col in lower.
enable_out  out  1  address_out valid this cycle.
cs_out  out  1  chip select; high throughout RUN.
last_out  out  1  high with the final address of the tile.
busy  out  1  high from accepted start until done.
done  out  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: one clock, sys_clk; reset is asynchronous and active-low (reset_n). Reset forces IDLE, clears the counters, and drives every output to 0.
- All outputs are registered. States are IDLE, RUN and DRAIN.
- IDLE:
  - An edge with start=1 and abort=0 latches rows_cfg/cols_cfg, clears row=col=0, sets busy<=1 and moves to RUN.
  - The other outputs stay 0 on that edge.
- RUN, each edge:
  - abort=1: go to IDLE and clear all outputs; done is not asserted.
  - stall=0:
    - address_out<={row,col}, enable_out<=1, cs_out<=1.
    - last_out<=(row==rows_lat && col==cols_lat).
    - Advance col. When col==cols_lat, col<=0 and row<=row+1.
    - If the element issued was the last one, go to DRAIN.
  - stall=1: enable_out<=0, last_out<=0, cs_out<=1; address_out and the counters hold.
- DRAIN:
  - enable_out<=0, cs_out<=0, last_out<=0; address_out holds its last value; stall is ignored.
  - A drain counter runs for NUM_PE edges. On the NUM_PE-th edge: done<=1 for one cycle, busy<=0, go to IDLE.
  - abort=1 returns to IDLE without done.
- Latency, with start sampled at edge k, N=(rows+1)*(cols+1) and S stall cycles:
  - First address is visible after edge k+1 if not stalled.
  - Last address is issued at edge k+N+S.
  - done and busy fall at edge k+N+S+NUM_PE.
- start while busy is ignored. start and abort on the same IDLE edge: abort wins and the block stays IDLE.
- rows_cfg=cols_cfg=0 issues a single address 0 with last_out=1 on that same cycle.
- Full size (all-ones cfg): the row counter never wraps past rows_lat; the final address is all ones. The counters need no extra bit beyond FEATURE_BITS, because the last-element check happens before the increment.
- Changing cfg inputs during busy has no effect.
- Async reset mid-RUN or mid-DRAIN returns to IDLE immediately with all outputs 0; no done pulse.

Test Plan:
- Reset: hold reset_n=0 with start=1 -> all outputs 0. Release -> the block stays IDLE until start is sampled.
- rows_cfg=1, cols_cfg=2, stall=0:
  - address_out is 0x00,0x01,0x02,0x10,0x11,0x12 on six consecutive cycles, with enable_out=1 and cs_out=1.
  - last_out is high only with 0x12.
  - done pulses 4 cycles after the 0x12 cycle; busy is high for 10 cycles.
- Same config with stall=1 for 2 cycles after 0x01 issues:
  - enable_out=0 for 2 cycles while address_out holds 0x01 and cs_out=1.
  - The stream then resumes at 0x02; done arrives 2 cycles later than the unstalled case.
- rows_cfg=cols_cfg=0 -> a single cycle of 0x00 with enable_out=1 and last_out=1, 4 drain cycles, done; a start pulsed during DRAIN is ignored.
- rows_cfg=cols_cfg=15 -> 256 sequential addresses 0x00..0xFF, last_out only on 0xFF, no wrap to 0x00; done follows 4 cycles later.
- Abort mid-RUN at 0x11, and separately abort during DRAIN -> IDLE on the next edge with all outputs 0 and no done. A new start afterwards reruns from 0x00 correctly.

Source files
------------

// File: rtl/sa_fetch_controller.sv
// rtl/sa_fetch_controller.sv - operand fetch sequencer for the systolic array delay chain
//
// Walks a (rows_cfg+1) x (cols_cfg+1) tile in row-major order, issuing one
// {row,col} address per non-stalled cycle. It then drains for NUM_PE cycles
// so the most-delayed PE column sees the final element, and pulses done.
//
// Ports:
//   sys_clk      system clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        start request, only honoured in IDLE
//   abort        synchronous abort, returns to IDLE from any state without done
//   stall        hold issue for this cycle (RUN only)
//   rows_cfg     rows minus 1, latched at start
//   cols_cfg     cols minus 1, latched at start
//   address_out  {row,col} of the issued element
//   enable_out   address_out valid this cycle
//   cs_out       chip select, high throughout RUN
//   last_out     high with the final address of the tile
//   busy         high from accepted start until done
//   done         one-cycle completion pulse

module sa_fetch_controller #(
    parameter int FEATURE_BITS = 4,
    parameter int NUM_PE       = 4
) (
    input  logic                      sys_clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      stall,
    input  logic [FEATURE_BITS-1:0]   rows_cfg,
    input  logic [FEATURE_BITS-1:0]   cols_cfg,
    output logic [2*FEATURE_BITS-1:0] address_out,
    output logic                      enable_out,
    output logic                      cs_out,
    output logic                      last_out,
    output logic                      busy,
    output logic                      done
);

    localparam int AW = 2 * FEATURE_BITS;
    localparam int DW = $clog2(NUM_PE + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [FEATURE_BITS-1:0] row_q, row_d;
    logic [FEATURE_BITS-1:0] col_q, col_d;
    logic [FEATURE_BITS-1:0] rows_lat_q, rows_lat_d;
    logic [FEATURE_BITS-1:0] cols_lat_q, cols_lat_d;
    logic [DW-1:0]           drain_q, drain_d;
    logic [AW-1:0]           address_q, address_d;
    logic                    enable_q, enable_d;
    logic                    cs_q, cs_d;
    logic                    last_q, last_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    // The last-element test is made on the current counters, before any
    // increment, so the counters never need a carry bit even at full size.
    logic col_end;
    logic is_last;
    assign col_end = (col_q == cols_lat_q);
    assign is_last = col_end && (row_q == rows_lat_q);

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        rows_lat_d = rows_lat_q;
        cols_lat_d = cols_lat_q;
        drain_d    = drain_q;
        address_d  = address_q;
        enable_d   = 1'b0;
        cs_d       = 1'b0;
        last_d     = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                // abort has priority over a coincident start
                if (start && !abort) begin
                    rows_lat_d = rows_cfg;
                    cols_lat_d = cols_cfg;
                    row_d      = '0;
                    col_d      = '0;
                    address_d  = '0;
                    busy_d     = 1'b1;
                    state_d    = RUN;
                end
            end

            RUN: begin
                if (abort) begin
                    address_d = '0;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end else if (!stall) begin
                    address_d = {row_q, col_q};
                    enable_d  = 1'b1;
                    cs_d      = 1'b1;
                    last_d    = is_last;
                    if (col_end) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (is_last) begin
                        drain_d = '0;
                        state_d = DRAIN;
                    end
                end else begin
                    // address and counters hold; chip stays selected
                    cs_d = 1'b1;
                end
            end

            DRAIN: begin
                if (abort) begin
                    address_d = '0;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end else if (drain_q == DW'(NUM_PE - 1)) begin
                    address_d = '0;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end

            default: begin
                address_d = '0;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            rows_lat_q <= '0;
            cols_lat_q <= '0;
            drain_q    <= '0;
            address_q  <= '0;
            enable_q   <= 1'b0;
            cs_q       <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            rows_lat_q <= rows_lat_d;
            cols_lat_q <= cols_lat_d;
            drain_q    <= drain_d;
            address_q  <= address_d;
            enable_q   <= enable_d;
            cs_q       <= cs_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign address_out = address_q;
    assign enable_out  = enable_q;
    assign cs_out      = cs_q;
    assign last_out    = last_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_sa_fetch_controller.sv
// tb/tb_sa_fetch_controller.sv - self-checking bench for sa_fetch_controller
module tb_sa_fetch_controller;

    localparam int FB = 4;
    localparam int NP = 4;

    logic            sys_clk = 1'b0;
    logic            reset_n;
    logic            start;
    logic            abort;
    logic            stall;
    logic [FB-1:0]   rows_cfg;
    logic [FB-1:0]   cols_cfg;
    logic [2*FB-1:0] address_out;
    logic            enable_out;
    logic            cs_out;
    logic            last_out;
    logic            busy;
    logic            done;

    int total = 0;
    int bad   = 0;

    sa_fetch_controller #(.FEATURE_BITS(FB), .NUM_PE(NP)) dut (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .stall       (stall),
        .rows_cfg    (rows_cfg),
        .cols_cfg    (cols_cfg),
        .address_out (address_out),
        .enable_out  (enable_out),
        .cs_out      (cs_out),
        .last_out    (last_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] a, input logic en,
                           input logic cs, input logic lst, input logic bsy,
                           input logic dn, input bit check_addr);
        if (check_addr) chk({tag, ".addr"}, 32'(address_out), 32'(a));
        chk({tag, ".en"},   32'(enable_out), 32'(en));
        chk({tag, ".cs"},   32'(cs_out),     32'(cs));
        chk({tag, ".last"}, 32'(last_out),   32'(lst));
        chk({tag, ".busy"}, 32'(busy),       32'(bsy));
        chk({tag, ".done"}, 32'(done),       32'(dn));
    endtask

    // Row-major element index -> {row,col}
    function automatic logic [7:0] elem_addr(input int idx, input int cols);
        int r;
        int c;
        r = idx / (cols + 1);
        c = idx % (cols + 1);
        return 8'(r * 16 + c);
    endfunction

    // mode: 0 no stall, 1 two stall cycles once 0x01 has issued, 2 random stalls.
    // abort_idx: abort on the edge that would issue element abort_idx (-1 none).
    // abort_drain: abort on that drain edge number (1-based, -1 none).
    task automatic run_tile(input int r, input int c, input int mode,
                            input int abort_idx, input int abort_drain);
        int         n;
        int         issued;
        int         drain;
        int         stall_cnt;
        bit         fin;
        bit         do_abort;
        logic [7:0] held;
        n = (r + 1) * (c + 1);
        issued = 0;
        drain = 0;
        stall_cnt = 0;
        fin = 1'b0;
        held = 8'h00;

        @(negedge sys_clk);
        start = 1'b1; abort = 1'b0; stall = 1'b0;
        rows_cfg = FB'(r); cols_cfg = FB'(c);
        @(posedge sys_clk); #1;
        chk_all("start", 8'h00, 0, 0, 0, 1, 0, 1);

        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            @(negedge sys_clk);
            // start and cfg changes while busy must have no effect
            start    = 1'($urandom_range(0, 1));
            rows_cfg = FB'($urandom);
            cols_cfg = FB'($urandom);
            case (mode)
                1:       stall = (issued == 2 && stall_cnt < 2);
                2:       stall = ($urandom_range(0, 3) == 0);
                default: stall = 1'b0;
            endcase
            do_abort = (issued < n && issued == abort_idx) ||
                       (issued == n && drain + 1 == abort_drain);
            abort = do_abort;
            @(posedge sys_clk); #1;
            if (do_abort) begin
                chk_all("abort", 8'h00, 0, 0, 0, 0, 0, 1);
                fin = 1'b1;
            end else if (issued < n) begin
                if (!stall) begin
                    held = elem_addr(issued, c);
                    chk_all("issue", held, 1, 1, (issued == n - 1), 1, 0, 1);
                    issued++;
                end else begin
                    stall_cnt++;
                    chk_all("stall", held, 0, 1, 0, 1, 0, 1);
                end
            end else begin
                drain++;
                if (drain == NP) begin
                    chk_all("done", 8'h00, 0, 0, 0, 0, 1, 0);
                    fin = 1'b1;
                end else begin
                    chk_all("drain", held, 0, 0, 0, 1, 0, 1);
                end
            end
        end
        chk("tile_finished", 32'(fin), 32'd1);

        @(negedge sys_clk);
        start = 1'b0; abort = 1'b0; stall = 1'b0;
        @(posedge sys_clk); #1;
        chk_all("post_idle", 8'h00, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b1; abort = 1'b0; stall = 1'b0;
        rows_cfg = 4'h3; cols_cfg = 4'h3;
        #1;
        chk_all("reset_async", 8'h00, 0, 0, 0, 0, 0, 1);
        repeat (3) @(posedge sys_clk);
        #1;
        chk_all("reset_hold", 8'h00, 0, 0, 0, 0, 0, 1);

        @(negedge sys_clk);
        reset_n = 1'b1; start = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk_all("idle_after_reset", 8'h00, 0, 0, 0, 0, 0, 1);

        // start and abort together: abort wins
        @(negedge sys_clk);
        start = 1'b1; abort = 1'b1;
        @(posedge sys_clk); #1;
        chk_all("start_abort", 8'h00, 0, 0, 0, 0, 0, 1);
        @(negedge sys_clk);
        start = 1'b0; abort = 1'b0;

        run_tile(1, 2, 0, -1, -1);
        run_tile(1, 2, 1, -1, -1);
        run_tile(0, 0, 0, -1, -1);
        run_tile(15, 15, 0, -1, -1);
        run_tile(1, 2, 0, 5, -1);
        run_tile(1, 2, 0, -1, 2);
        run_tile(1, 2, 0, -1, -1);
        run_tile(3, 3, 2, -1, -1);
        for (int i = 0; i < 6; i++) begin
            run_tile(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), 2, -1, -1);
        end

        // asynchronous reset mid-RUN
        @(negedge sys_clk);
        start = 1'b1; rows_cfg = 4'h3; cols_cfg = 4'h3;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (3) @(negedge sys_clk);
        #2 reset_n = 1'b0;
        #1;
        chk_all("reset_mid_run", 8'h00, 0, 0, 0, 0, 0, 1);
        @(negedge sys_clk);
        reset_n = 1'b1;
        repeat (6) @(posedge sys_clk);
        #1;
        chk_all("idle_after_run_reset", 8'h00, 0, 0, 0, 0, 0, 1);

        // asynchronous reset mid-DRAIN
        @(negedge sys_clk);
        start = 1'b1; rows_cfg = 4'h0; cols_cfg = 4'h0;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (2) @(negedge sys_clk);
        #2 reset_n = 1'b0;
        #1;
        chk_all("reset_mid_drain", 8'h00, 0, 0, 0, 0, 0, 1);
        @(negedge sys_clk);
        reset_n = 1'b1;
        repeat (6) @(posedge sys_clk);
        #1;
        chk_all("idle_after_drain_reset", 8'h00, 0, 0, 0, 0, 0, 1);

        run_tile(1, 2, 0, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
